// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Issues sequential word reads on a
//               req/ack memory port (one outstanding at a time), buffers the
//               returned words tagged with their PC in a prefetch FIFO, and
//               hands them to the datapath over valid/ready. A redirect
//               flushes the FIFO and restarts fetch at the new target.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned         c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]       c_depth   = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw-1:0]     c_ptr_one = (c_aw)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_disc_addr;
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_aw:0]   r_count;
  logic [c_aw:0]   w_count_nxt;
  logic [31:0]     r_fifo_instr [DEPTH];
  logic [31:0]     r_fifo_pc    [DEPTH];
  logic            w_push;
  logic            w_pop;
  logic            w_unused;

  // Low bits of the redirect target are forced to zero, so they are never read.
  assign w_unused = ^redirect_pc[1:0];

  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid & instr_ready;
  // A word returned together with a redirect belongs to the old path: drop it.
  assign w_push      = (r_state == S_REQ) & mem_ack & ~redirect;

  assign instr    = instr_valid ? r_fifo_instr[r_rptr] : 32'h0;
  assign instr_pc = instr_valid ? r_fifo_pc[r_rptr]    : 32'h0;

  // Occupancy update; a redirect empties the FIFO (the head pop, if any, is
  // still seen by the datapath this cycle).
  always_comb begin
    w_count_nxt = r_count;
    if (redirect) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};
    end
  end

  // Fetch FSM next-state and memory port outputs.
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_addr    = r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (!redirect && (r_count < c_depth)) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (redirect) begin
          // An in-flight request cannot be withdrawn; wait it out in DISCARD.
          w_state_nxt = mem_ack ? S_REQ : S_DISCARD;
        end else if (mem_ack) begin
          w_state_nxt = (w_count_nxt < c_depth) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = r_disc_addr;
        if (mem_ack) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, fetch PC, abandoned-request address, FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_disc_addr <= RESET_PC;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if ((r_state == S_REQ) && redirect && !mem_ack) begin
        r_disc_addr <= r_fetch_pc;
      end
      if (redirect) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + c_ptr_one;
        if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
      end
    end
  end

  // FIFO storage: each entry holds the instruction word and its PC.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= mem_rdata;
      r_fifo_pc[r_wptr]    <= r_fetch_pc;
    end
  end

endmodule
`default_nettype wire
